inst_loader: RTL
================

Name: inst_loader

Overview:
- Host-side writer for the processor's instruction-memory write port (mem_write / 32-bit mem_in); the counterpart of the fetch-side reader.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to sequential instruction-memory addresses and holds the core stalled until the image is complete.
- Sits between the external host link and the processor top.

Parameters:
- WORD, 32, instruction word width (fixed at 4 bytes).
- ADDR, 16, instruction-memory word-address width.
- BASE, 0, word address of the first loaded instruction.
- DEPTH, 1024, instruction-memory capacity in words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that re-arms the loader from DONE.
- byte_valid_i  in  1  host byte valid.
- byte_i  in  8  host byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_write_o  out  1  instruction-memory write strobe (drives mem_write).
- mem_addr_o  out  ADDR  instruction-memory write word address.
- mem_data_o  out  WORD  instruction-memory write data (drives mem_in).
- stall_o  out  1  holds the core (drives stall_i) while loading.
- done_o  out  1  one-cycle pulse when the load completes.
- err_o  out  1  sticky: image exceeded DEPTH.

Behaviour:
- Reset (reset==0, asynchronous):
  - State LEN0; byte_ready_o=1, stall_o=1.
  - mem_write_o=0, mem_addr_o=BASE, mem_data_o=0, done_o=0, err_o=0.
  - Byte counter=0, word count N=0.
  - Asserting reset mid-load aborts immediately; partial words are discarded and nothing further is written.
- Handshake:
  - A byte transfers on a rising edge with byte_valid_i && byte_ready_o.
  - byte_ready_o=1 in LEN0, LEN1 and DATA; 0 in DONE. Throughput is one byte per cycle, with no back-pressure inside DATA.
- FSM:
  - LEN0: on transfer, N[7:0]=byte; go to LEN1.
  - LEN1: on transfer, N[15:8]=byte.
    - If the full 16-bit N==0, go to DONE and pulse done_o next cycle.
    - Otherwise go to DATA.
  - DATA: bytes fill the word little-endian (first byte → bits 7:0, 4th byte → bits 31:24).
    - On the 4th byte, next cycle: mem_write_o=1 for exactly one cycle, mem_data_o=assembled word, mem_addr_o=current address.
    - Address increments by 1 after each write and wraps modulo 2^ADDR.
    - After word N is written, go to DONE.
  - DONE: stall_o=0; done_o pulses for one cycle on entry; byte_ready_o=0.
    - On start_i: go to LEN0, stall_o=1, address=BASE, err_o cleared.
    - start_i in any other state is ignored.
- Capacity:
  - Words with index ≥ DEPTH (0-based, counted from BASE) are still consumed from the stream but not written (mem_write_o stays 0).
  - err_o is set when the first such word completes and stays set until start_i or reset.
- Latency: 4th byte accepted at edge k → mem_write_o high in cycle k+1 → for the last word, DONE entered and done_o high in cycle k+2.
- mem_data_o and mem_addr_o hold their last values when mem_write_o=0.
- byte_valid_i while byte_ready_o=0 is ignored; no bytes are lost or counted.
- Simultaneous start_i and byte_valid_i in DONE: the restart takes effect; the byte is not accepted (ready is 0 that cycle).

Test Plan:
- Reset, then stream 02 00 | 13 00 00 00 | EF BE AD DE → writes 0x00000013 @0, then 0xDEADBEEF @1. Each mem_write_o is a single-cycle pulse. done_o pulses once, stall_o falls, err_o=0.
- Header 00 00 → no writes; done_o one cycle after the LEN1 byte; stall_o=0.
- Same two-word image with byte_valid_i toggled every other cycle → identical writes and addresses; no byte is dropped or duplicated.
- DEPTH=2, N=3, three words → writes only at addresses 0 and 1; third word consumed with no write; err_o=1 stays set in DONE; start_i clears it.
- reset pulled low after 6 data bytes of a 2-word image → outputs return to reset values immediately. A following 1-word image writes at BASE with correct data.
- BASE=0xFFFF, ADDR=16, N=2 → writes at 0xFFFF then 0x0000 (wrap).

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: host-side writer for the instruction-memory write port.
//
// Takes a byte stream (valid/ready), reads a 16-bit little-endian word count N,
// then assembles N little-endian 32-bit words. Each word is written to sequential
// word addresses starting at BASE. The core is held stalled until the image is complete.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start_i       one-cycle pulse; re-arms the loader from DONE
//   byte_valid_i  host byte valid
//   byte_i        host byte
//   byte_ready_o  loader accepts a byte this cycle
//   mem_write_o   instruction-memory write strobe (one cycle per word)
//   mem_addr_o    instruction-memory write word address
//   mem_data_o    instruction-memory write data
//   stall_o       holds the core while loading
//   done_o        one-cycle pulse when the load completes
//   err_o         sticky: image exceeded DEPTH words
module inst_loader #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned ADDR  = 16,
  parameter int unsigned BASE  = 0,
  parameter int unsigned DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_i,
  output logic            byte_ready_o,
  output logic            mem_write_o,
  output logic [ADDR-1:0] mem_addr_o,
  output logic [WORD-1:0] mem_data_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [ADDR-1:0] BaseAddr = ADDR'(BASE);
  localparam logic [16:0]     DepthW   = 17'(DEPTH);

  // StFlush covers the cycle in which the last word is being written: no bytes
  // are accepted there, and DONE (with its done pulse) follows one cycle later.
  typedef enum logic [2:0] {StLen0, StLen1, StData, StFlush, StDone} state_e;

  state_e r_state, w_state_d;

  logic [15:0]      r_n;
  logic [1:0]       r_byte_cnt;
  logic [WORD-9:0]  r_shift;      // first three bytes of the word in progress
  logic [15:0]      r_word_idx;   // words completed so far in this image
  logic [ADDR-1:0]  r_next_addr;
  logic [ADDR-1:0]  r_mem_addr;
  logic [WORD-1:0]  r_mem_data;
  logic             r_write;
  logic             r_done;
  logic             r_err;

  logic             w_xfer;
  logic             w_word_end;
  logic             w_last;
  logic             w_in_range;
  logic [15:0]      w_n_full;

  assign w_xfer     = byte_valid_i && byte_ready_o;
  assign w_n_full   = {byte_i, r_n[7:0]};
  assign w_word_end = (r_state == StData) && w_xfer && (r_byte_cnt == 2'd3);
  assign w_last     = (r_word_idx == (r_n - 16'd1));
  assign w_in_range = ({1'b0, r_word_idx} < DepthW);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StLen0;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLen0:  if (w_xfer) w_state_d = StLen1;
      StLen1:  if (w_xfer) w_state_d = (w_n_full == 16'd0) ? StDone : StData;
      StData:  if (w_word_end && w_last) w_state_d = StFlush;
      StFlush: w_state_d = StDone;
      StDone:  if (start_i) w_state_d = StLen0;
      default: w_state_d = StLen0;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    byte_ready_o = 1'b0;
    stall_o      = 1'b1;
    unique case (r_state)
      StLen0, StLen1, StData: byte_ready_o = 1'b1;
      StDone:                 stall_o      = 1'b0;
      default:                ;
    endcase
  end

  assign mem_write_o = r_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_data_o  = r_mem_data;
  assign done_o      = r_done;
  assign err_o       = r_err;

  // Datapath: header capture, word assembly, write strobe and address tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n         <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_word_idx  <= '0;
      r_next_addr <= BaseAddr;
      r_mem_addr  <= BaseAddr;
      r_mem_data  <= '0;
      r_write     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_write <= 1'b0;
      // done pulses only in the first cycle of DONE
      r_done  <= (w_state_d == StDone) && (r_state != StDone);

      if ((r_state == StDone) && start_i) begin
        r_n         <= '0;
        r_byte_cnt  <= '0;
        r_word_idx  <= '0;
        r_next_addr <= BaseAddr;
        r_err       <= 1'b0;
      end

      if (w_xfer) begin
        if (r_state == StLen0) r_n[7:0]  <= byte_i;
        if (r_state == StLen1) r_n[15:8] <= byte_i;
        if (r_state == StData) begin
          r_shift    <= {byte_i, r_shift[WORD-9:8]};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_word_idx <= r_word_idx + 16'd1;
            if (w_in_range) begin
              r_write     <= 1'b1;
              r_mem_data  <= {byte_i, r_shift};
              r_mem_addr  <= r_next_addr;
              r_next_addr <= r_next_addr + 1'b1;
            end else begin
              // word beyond capacity: consumed, not written
              r_err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
